// File: rtl/memory_initiator_pkg.sv
// Shared definitions for the memory initiator: MemoryInterface command codes,
// access sizes, controller states and request decode helpers.
package memory_initiator_pkg;

    localparam logic [3:0] CMD_NOP = 4'h0;
    localparam logic [3:0] CMD_RB  = 4'h1;
    localparam logic [3:0] CMD_RS  = 4'h2;
    localparam logic [3:0] CMD_RW  = 4'h3;
    localparam logic [3:0] CMD_WB  = 4'h4;
    localparam logic [3:0] CMD_WS  = 4'h5;
    localparam logic [3:0] CMD_WW  = 4'h6;
    localparam logic [3:0] CMD_HAW = 4'h7;
    localparam logic [3:0] CMD_DR  = 4'h8;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_SHORT   = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAITRDY = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } mi_state_e;

    function automatic logic [3:0] cmd_encode(input logic write, input logic [1:0] size);
        logic [3:0] cmd;
        case ({write, size})
            3'b000:  cmd = CMD_RB;
            3'b001:  cmd = CMD_RS;
            3'b010:  cmd = CMD_RW;
            3'b100:  cmd = CMD_WB;
            3'b101:  cmd = CMD_WS;
            3'b110:  cmd = CMD_WW;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

    function automatic logic req_is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE:    bad = 1'b0;
            SIZE_SHORT:   bad = addr_lo[0];
            SIZE_WORD:    bad = (addr_lo != 2'b00);
            SIZE_ILLEGAL: bad = 1'b1;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_initiator_if.sv
// Core-side request/response channel and MemoryInterface bus channel used by
// the memory initiator.
interface memory_core_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddress;
    logic [31:0] reqData;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspError;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
        input  reqReady, rspValid, rspData, rspError
    );
    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqData,
        output reqReady, rspValid, rspData, rspError
    );
endinterface

interface memory_bus_if;
    logic [3:0]  cCommand;
    logic [31:0] cAddress;
    logic [31:0] cData;
    logic        hReady;
    logic        hSignal;
    logic [31:0] hData;

    modport master (
        output cCommand, cAddress, cData,
        input  hReady, hSignal, hData
    );
    modport slave (
        input  cCommand, cAddress, cData,
        output hReady, hSignal, hData
    );
endinterface

// File: rtl/memory_load_extend.sv
// Right-aligned read data to core width: byte/short are sign- or
// zero-extended, words pass straight through.
module memory_load_extend
    import memory_initiator_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] hdata_i,
    output logic [31:0] data_o
);

    // Extension select by access size
    always_comb begin
        data_o = hdata_i;
        case (size_i)
            SIZE_BYTE:  data_o = {{24{signed_i & hdata_i[7]}}, hdata_i[7:0]};
            SIZE_SHORT: data_o = {{16{signed_i & hdata_i[15]}}, hdata_i[15:0]};
            default:    data_o = hdata_i;
        endcase
    end

endmodule

// File: rtl/memory_initiator.sv
// Initiator end of the MemoryInterface protocol: one core load/store at a time,
// framed NOP -> CMD -> NOP on the bus, one response pulse back to the core.
module memory_initiator
    import memory_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input logic          clock,
    input logic          reset,
    memory_core_if.slave core,
    memory_bus_if.master bus
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;

    mi_state_e   state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] caddr_q, caddr_d;
    logic [31:0] cdata_q, cdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        timeout_s;
    logic [31:0] ext_s;

    memory_load_extend u_extend (
        .size_i   (size_q),
        .signed_i (signed_q),
        .hdata_i  (bus.hData),
        .data_o   (ext_s)
    );

    assign timeout_s = (TIMEOUT != 32'd0) && (cnt_q == CNT_W'(TIMEOUT - 32'd1));

    // Next-state, request latching and registered-output next values
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (core.reqValid) begin
                    write_d  = core.reqWrite;
                    size_d   = core.reqSize;
                    signed_d = core.reqSigned;
                    addr_d   = core.reqAddress;
                    wdata_d  = core.reqData;
                    rdata_d  = 32'd0;
                    err_d    = req_is_illegal(core.reqSize, core.reqAddress[1:0]);
                    state_d  = err_d ? ST_RESP : ST_WAITRDY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAITRDY: begin
                if (bus.hReady && !bus.hSignal) begin
                    state_d = ST_ISSUE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_WAITRDY;
                end
            end
            ST_ISSUE: begin
                if (bus.hSignal) begin
                    rdata_d = ext_s;
                    state_d = ST_RELEASE;
                end else if (timeout_s) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RELEASE: begin
                // Wait for the responder to drop its completion flag
                if (!bus.hSignal) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_d = (state_d == ST_ISSUE) ? cmd_encode(write_d, size_d) : CMD_NOP;

        if ((state_q == ST_WAITRDY) && (state_d == ST_ISSUE)) begin
            caddr_d = addr_q;
            cdata_d = write_q ? wdata_q : 32'd0;
        end else begin
            caddr_d = caddr_q;
            cdata_d = cdata_q;
        end

        rsp_valid_d = (state_d == ST_RESP);
        if (state_d == ST_RESP) begin
            rsp_err_d  = err_d;
            rsp_data_d = (write_d || err_d) ? 32'd0 : rdata_d;
        end else begin
            rsp_err_d  = rsp_err_q;
            rsp_data_d = rsp_data_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            cmd_q       <= CMD_NOP;
            caddr_q     <= 32'd0;
            cdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            caddr_q     <= caddr_d;
            cdata_q     <= cdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign core.reqReady = (state_q == ST_IDLE) && !reset;
    assign core.rspValid = rsp_valid_q;
    assign core.rspData  = rsp_data_q;
    assign core.rspError = rsp_err_q;
    assign bus.cCommand  = cmd_q;
    assign bus.cAddress  = caddr_q;
    assign bus.cData     = cdata_q;

endmodule

// File: tb/tb_memory_initiator.sv
// Directed bench for memory_initiator with a scripted responder on the bus side.
module tb_memory_initiator;
    import memory_initiator_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    memory_core_if core ();
    memory_bus_if  bus ();

    memory_initiator #(.TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .core  (core),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          obs_lat;
    int          obs_ncmd;
    int          obs_issue;
    int          obs_rsp_count;
    logic        obs_unstable;
    logic        obs_bad;
    logic        obs_ready_pre;
    logic        obs_ready_rsp;
    logic [3:0]  obs_cmd;
    logic [31:0] obs_addr;
    logic [31:0] obs_data;
    logic [31:0] obs_rdata;
    logic        obs_err;

    // One request; responder raises hSignal for one cycle, delay cycles after the command (delay<0: never)
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay, input logic [31:0] hd);
        int first_cmd;
        logic [3:0] prev_cmd;
        @(negedge clock);
        obs_ready_pre   = core.reqReady;
        core.reqValid   = 1'b1;
        core.reqWrite   = w;
        core.reqSize    = sz;
        core.reqSigned  = sg;
        core.reqAddress = addr;
        core.reqData    = wd;
        @(negedge clock);
        core.reqValid = 1'b0;
        obs_lat = -1; obs_ncmd = 0; obs_issue = 0; obs_rsp_count = 0;
        obs_unstable = 1'b0; obs_bad = 1'b0; obs_ready_rsp = 1'b1;
        obs_cmd = CMD_NOP; obs_addr = 32'd0; obs_data = 32'd0; obs_rdata = 32'hDEAD_DEAD; obs_err = 1'b0;
        first_cmd = 0;
        prev_cmd  = CMD_NOP;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (bus.cCommand == CMD_HAW || bus.cCommand == CMD_DR) obs_bad = 1'b1;
            if (bus.cCommand != CMD_NOP) begin
                if (prev_cmd == CMD_NOP) begin
                    obs_ncmd++;
                    first_cmd = cyc;
                    obs_cmd   = bus.cCommand;
                    obs_addr  = bus.cAddress;
                    obs_data  = bus.cData;
                end else if (bus.cCommand != obs_cmd || bus.cAddress != obs_addr || bus.cData != obs_data) begin
                    obs_unstable = 1'b1;
                end
                obs_issue++;
            end
            prev_cmd = bus.cCommand;
            if (core.rspValid) begin
                if (obs_lat < 0) begin
                    obs_lat       = cyc;
                    obs_rdata     = core.rspData;
                    obs_err       = core.rspError;
                    obs_ready_rsp = core.reqReady;
                end
                obs_rsp_count++;
            end
            bus.hSignal = (delay >= 0 && first_cmd > 0 && cyc == first_cmd + delay) ? 1'b1 : 1'b0;
            bus.hData   = hd;
            if (obs_lat >= 0 && cyc >= obs_lat + 2) break;
        end
        bus.hSignal = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core.reqValid = 1'b0; core.reqWrite = 1'b0; core.reqSize = 2'd0; core.reqSigned = 1'b0;
        core.reqAddress = 32'd0; core.reqData = 32'd0;
        bus.hReady = 1'b1; bus.hSignal = 1'b0; bus.hData = 32'd0;
        repeat (3) @(negedge clock);
        checks++; if (bus.cCommand !== CMD_NOP) begin errors++; $display("FAIL rst_cmd got %h exp %h", bus.cCommand, CMD_NOP); end
        checks++; if (bus.cAddress !== 32'd0) begin errors++; $display("FAIL rst_caddr got %h exp 0", bus.cAddress); end
        checks++; if (bus.cData !== 32'd0) begin errors++; $display("FAIL rst_cdata got %h exp 0", bus.cData); end
        checks++; if (core.rspValid !== 1'b0) begin errors++; $display("FAIL rst_rspvalid got %b exp 0", core.rspValid); end
        checks++; if (core.rspData !== 32'd0) begin errors++; $display("FAIL rst_rspdata got %h exp 0", core.rspData); end
        checks++; if (core.rspError !== 1'b0) begin errors++; $display("FAIL rst_rsperr got %b exp 0", core.rspError); end
        checks++; if (core.reqReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", core.reqReady); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (core.reqReady !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", core.reqReady); end
    endtask

    task automatic test_load_word();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h8000_00F0);
        checks++; if (obs_ready_pre !== 1'b1) begin errors++; $display("FAIL lw_ready got %b exp 1", obs_ready_pre); end
        checks++; if (obs_cmd !== CMD_RW) begin errors++; $display("FAIL lw_cmd got %h exp %h", obs_cmd, CMD_RW); end
        checks++; if (obs_addr !== 32'h0000_0100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", obs_addr); end
        checks++; if (obs_data !== 32'd0) begin errors++; $display("FAIL lw_cdata got %h exp 0", obs_data); end
        checks++; if (obs_rdata !== 32'h8000_00F0) begin errors++; $display("FAIL lw_rdata got %h exp 800000f0", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", obs_err); end
        checks++; if (obs_lat != 5) begin errors++; $display("FAIL lw_latency got %0d exp 5", obs_lat); end
        checks++; if (obs_ncmd != 1 || obs_unstable || obs_bad) begin errors++; $display("FAIL lw_framing got ncmd %0d unstable %b bad %b exp 1 0 0", obs_ncmd, obs_unstable, obs_bad); end
        checks++; if (obs_rsp_count != 1) begin errors++; $display("FAIL lw_pulse got %0d exp 1", obs_rsp_count); end
        checks++; if (obs_ready_rsp !== 1'b0) begin errors++; $display("FAIL lw_ready_in_resp got %b exp 0", obs_ready_rsp); end
    endtask

    task automatic test_load_extend();
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'd0, 1, 32'h0000_0080);
        checks++; if (obs_cmd !== CMD_RB) begin errors++; $display("FAIL lbs_cmd got %h exp %h", obs_cmd, CMD_RB); end
        checks++; if (obs_addr !== 32'h0000_0003) begin errors++; $display("FAIL lbs_addr got %h exp 00000003", obs_addr); end
        checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lbs_rdata got %h exp ffffff80", obs_rdata); end
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'd0, 1, 32'h0000_0080);
        checks++; if (obs_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lbu_err got %b exp 0", obs_err); end
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'd0, 1, 32'hABCD_8001);
        checks++; if (obs_cmd !== CMD_RS) begin errors++; $display("FAIL lhs_cmd got %h exp %h", obs_cmd, CMD_RS); end
        checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lhs_rdata got %h exp ffff8001", obs_rdata); end
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'd0, 1, 32'hABCD_8001);
        checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", obs_rdata); end
    endtask

    task automatic test_store();
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_1234, 1, 32'hFFFF_FFFF);
        checks++; if (obs_cmd !== CMD_WS) begin errors++; $display("FAIL sh_cmd got %h exp %h", obs_cmd, CMD_WS); end
        checks++; if (obs_data !== 32'h0000_1234) begin errors++; $display("FAIL sh_cdata got %h exp 00001234", obs_data); end
        checks++; if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin errors++; $display("FAIL sh_rsp got data %h err %b exp 0 0", obs_rdata, obs_err); end
        checks++; if (obs_lat != 5) begin errors++; $display("FAIL sh_latency got %0d exp 5", obs_lat); end
        checks++; if (bus.cCommand !== CMD_NOP) begin errors++; $display("FAIL sh_nop_after got %h exp %h", bus.cCommand, CMD_NOP); end
        run_txn(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'd0);
        checks++; if (obs_cmd !== CMD_WW || obs_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_cmd got %h/%h exp %h/cafef00d", obs_cmd, obs_data, CMD_WW); end
        run_txn(1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_00A5, 1, 32'd0);
        checks++; if (obs_cmd !== CMD_WB || obs_addr !== 32'h0000_0011) begin errors++; $display("FAIL sb_cmd got %h/%h exp %h/00000011", obs_cmd, obs_addr, CMD_WB); end
    endtask

    task automatic test_errors();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'd0, 1, 32'h1111_1111);
        checks++; if (obs_lat != 1) begin errors++; $display("FAIL lw_mis_latency got %0d exp 1", obs_lat); end
        checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin errors++; $display("FAIL lw_mis_rsp got err %b data %h exp 1 0", obs_err, obs_rdata); end
        checks++; if (obs_ncmd != 0) begin errors++; $display("FAIL lw_mis_bus got %0d cmds exp 0", obs_ncmd); end
        run_txn(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 1, 32'd0);
        checks++; if (obs_lat != 1 || obs_err !== 1'b1 || obs_ncmd != 0) begin errors++; $display("FAIL size3 got lat %0d err %b ncmd %0d exp 1 1 0", obs_lat, obs_err, obs_ncmd); end
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0000_5555, 1, 32'd0);
        checks++; if (obs_lat != 1 || obs_err !== 1'b1 || obs_ncmd != 0) begin errors++; $display("FAIL sh_mis got lat %0d err %b ncmd %0d exp 1 1 0", obs_lat, obs_err, obs_ncmd); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, -1, 32'h7777_7777);
        checks++; if (obs_issue != 8) begin errors++; $display("FAIL to_issue_cycles got %0d exp 8", obs_issue); end
        checks++; if (obs_lat != 11) begin errors++; $display("FAIL to_latency got %0d exp 11", obs_lat); end
        checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin errors++; $display("FAIL to_rsp got err %b data %h exp 1 0", obs_err, obs_rdata); end
        checks++; if (bus.cCommand !== CMD_NOP || obs_ncmd != 1) begin errors++; $display("FAIL to_nop got %h ncmd %0d exp %h 1", bus.cCommand, obs_ncmd, CMD_NOP); end
    endtask

    task automatic test_reset_mid_issue();
        int bad_ready = 0;
        int bad_cmd   = 0;
        int pulses    = 0;
        @(negedge clock);
        bus.hReady = 1'b0;
        core.reqValid = 1'b1; core.reqWrite = 1'b0; core.reqSize = 2'd2; core.reqSigned = 1'b0;
        core.reqAddress = 32'h0000_0200; core.reqData = 32'd0;
        @(negedge clock);
        core.reqAddress = 32'h0000_0300;
        for (int i = 0; i < 10; i++) begin
            if (core.reqReady !== 1'b0) bad_ready++;
            if (bus.cCommand !== CMD_NOP) bad_cmd++;
            if (core.rspValid) pulses++;
            @(negedge clock);
        end
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL busy_ready got %0d high cycles exp 0", bad_ready); end
        checks++; if (bad_cmd != 0) begin errors++; $display("FAIL waitrdy_nop got %0d cmd cycles exp 0", bad_cmd); end
        core.reqValid = 1'b0;
        bus.hReady = 1'b1;
        @(negedge clock);
        checks++; if (bus.cCommand !== CMD_RW || bus.cAddress !== 32'h0000_0200) begin errors++; $display("FAIL mid_issue got %h/%h exp %h/00000200", bus.cCommand, bus.cAddress, CMD_RW); end
        repeat (2) begin @(negedge clock); if (core.rspValid) pulses++; end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.cCommand !== CMD_NOP || core.reqReady !== 1'b0) begin errors++; $display("FAIL mid_reset got cmd %h ready %b exp %h 0", bus.cCommand, core.reqReady, CMD_NOP); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (core.reqReady !== 1'b1 || bus.cAddress !== 32'd0) begin errors++; $display("FAIL post_reset got ready %b caddr %h exp 1 0", core.reqReady, bus.cAddress); end
        repeat (12) begin if (core.rspValid) pulses++; @(negedge clock); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL reset_no_rsp got %0d pulses exp 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_errors();
        test_timeout();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
